hawk_rd_arbiter: RTL and testbench



---
 rtl/hacd_pkg.sv | 26 ++
 rtl/hawk_rd_arbiter_if.sv | 47 ++++
 rtl/hawk_rr_picker.sv | 32 +++
 rtl/hawk_rd_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_hawk_rd_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hacd_pkg.sv
// Shared types and constants for the HAWK/HACD read-path blocks.
// HAWK_RD_ARB_TIMEOUT_EN adds the ABORT state used by the read arbiter watchdog.
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 128
`endif

package hacd_pkg;

  typedef enum logic [1:0] {
    RD_ARB_IDLE  = 2'd0,
    RD_ARB_ADDR  = 2'd1,
    RD_ARB_DATA  = 2'd2
`ifdef HAWK_RD_ARB_TIMEOUT_EN
    , RD_ARB_ABORT = 2'd3
`endif
  } rd_arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int unsigned RD_ARB_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/hawk_rd_arbiter_if.sv
// Requester-side and AXI4 read-master signals of hawk_rd_arbiter.
// The arbiter uses the slave modport; the requesters/memory model use master.
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 128
`endif

interface hawk_rd_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = `HACD_AXI4_ADDR_WIDTH,
  parameter int unsigned DATA_W  = `HACD_AXI4_DATA_WIDTH
) ();
  logic [NUM_REQ-1:0]        req_arvalid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*8-1:0]      req_arlen_i;
  logic [NUM_REQ-1:0]        req_arready_o;
  logic [NUM_REQ-1:0]        req_rvalid_o;
  logic [NUM_REQ-1:0]        req_rready_i;
  logic [DATA_W-1:0]         r_rdata_o;
  logic [1:0]                r_rresp_o;
  logic                      r_rlast_o;
  logic                      m_arvalid_o;
  logic [ADDR_W-1:0]         m_addr_o;
  logic [7:0]                m_arlen_o;
  logic                      m_arready_i;
  logic                      m_rvalid_i;
  logic                      m_rlast_i;
  logic [DATA_W-1:0]         m_rdata_i;
  logic [1:0]                m_rresp_i;
  logic                      m_rready_o;

  modport slave (
    input  req_arvalid_i, req_addr_i, req_arlen_i, req_rready_i,
           m_arready_i, m_rvalid_i, m_rlast_i, m_rdata_i, m_rresp_i,
    output req_arready_o, req_rvalid_o, r_rdata_o, r_rresp_o, r_rlast_o,
           m_arvalid_o, m_addr_o, m_arlen_o, m_rready_o
  );

  modport master (
    output req_arvalid_i, req_addr_i, req_arlen_i, req_rready_i,
           m_arready_i, m_rvalid_i, m_rlast_i, m_rdata_i, m_rresp_i,
    input  req_arready_o, req_rvalid_o, r_rdata_o, r_rresp_o, r_rlast_o,
           m_arvalid_o, m_addr_o, m_arlen_o, m_rready_o
  );
endinterface

// File: rtl/hawk_rr_picker.sv
// Combinational round-robin picker: first active request after last_grant_i,
// wrapping modulo NUM_REQ.
module hawk_rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       grant_valid_o
);
  localparam int unsigned OW = $clog2(NUM_REQ);

  // Slot gi of the rotated view is the requester gi+1 places after the last grant.
  logic [OW-1:0]      rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot_idx[gi] = OW'((32'(last_grant_i) + 32'(gi) + 32'd1) % NUM_REQ);
    assign cand[gi]    = req_i[rot_idx[gi]];
  end

  always_comb begin
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = rot_idx[i];
      end
    end
  end
endmodule

// File: rtl/hawk_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master between NUM_REQ requesters.
// Define HAWK_RD_ARB_TIMEOUT_EN to enable the watchdog and synthetic SLVERR abort beat.
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 128
`endif

module hawk_rd_arbiter
  import hacd_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = `HACD_AXI4_ADDR_WIDTH,
  parameter int unsigned DATA_W      = `HACD_AXI4_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYC = RD_ARB_TIMEOUT_CYC
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  hawk_rd_arbiter_if.slave           bus,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       proto_err_o,
  output logic                       timeout_err_o
);
  localparam int unsigned OW = $clog2(NUM_REQ);

  rd_arb_state_t     state_reg, state_next;
  logic [OW-1:0]     owner_reg, owner_next;
  logic [OW-1:0]     last_grant_reg, last_grant_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        len_reg, len_next;
  logic [7:0]        beat_cnt_reg, beat_cnt_next;
  logic              proto_err_reg, proto_err_next;

  logic [OW-1:0]      pick_idx;
  logic               pick_valid;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [ADDR_W-1:0]  req_addr [NUM_REQ];
  logic [7:0]         req_len  [NUM_REQ];
  logic               r_hs;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_addr[gi]     = bus.req_addr_i[gi*ADDR_W +: ADDR_W];
    assign req_len[gi]      = bus.req_arlen_i[gi*8 +: 8];
    assign owner_onehot[gi] = (owner_reg == OW'(gi));
  end

  hawk_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i         (bus.req_arvalid_i),
    .last_grant_i  (last_grant_reg),
    .grant_idx_o   (pick_idx),
    .grant_valid_o (pick_valid)
  );

  assign r_hs = (state_reg == RD_ARB_DATA) && bus.m_rvalid_i && bus.m_rready_o;

  // AR channel comes straight from registers; R channel is a zero-latency steer.
  always_comb begin
    bus.m_arvalid_o   = (state_reg == RD_ARB_ADDR);
    bus.m_addr_o      = addr_reg;
    bus.m_arlen_o     = len_reg;
    bus.req_arready_o = '0;
    bus.req_rvalid_o  = '0;
    bus.m_rready_o    = 1'b0;
    bus.r_rdata_o     = {DATA_W{1'b0}};
    bus.r_rresp_o     = AXI_RESP_OKAY;
    bus.r_rlast_o     = 1'b0;
    case (state_reg)
      RD_ARB_ADDR: begin
        if (bus.m_arready_i) bus.req_arready_o = owner_onehot;
      end
      RD_ARB_DATA: begin
        bus.m_rready_o = |(bus.req_rready_i & owner_onehot);
        if (bus.m_rvalid_i) bus.req_rvalid_o = owner_onehot;
        bus.r_rdata_o = bus.m_rdata_i;
        bus.r_rresp_o = bus.m_rresp_i;
        bus.r_rlast_o = bus.m_rlast_i;
      end
`ifdef HAWK_RD_ARB_TIMEOUT_EN
      RD_ARB_ABORT: begin
        bus.req_rvalid_o = owner_onehot;
        bus.r_rlast_o    = 1'b1;
        bus.r_rresp_o    = AXI_RESP_SLVERR;
      end
`endif
      default: ;
    endcase
  end

`ifdef HAWK_RD_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          to_err_reg, to_err_next;
`endif

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    addr_next       = addr_reg;
    len_next        = len_reg;
    beat_cnt_next   = beat_cnt_reg;
    proto_err_next  = proto_err_reg;
    case (state_reg)
      RD_ARB_IDLE: begin
        if (bus.m_rvalid_i) proto_err_next = 1'b1;
        if (pick_valid) begin
          owner_next = pick_idx;
          addr_next  = req_addr[pick_idx];
          len_next   = req_len[pick_idx];
          state_next = RD_ARB_ADDR;
        end
      end
      RD_ARB_ADDR: begin
        if (bus.m_rvalid_i) proto_err_next = 1'b1;
        if (bus.m_arready_i) begin
          beat_cnt_next = '0;
          state_next    = RD_ARB_DATA;
        end
      end
      RD_ARB_DATA: begin
        // beat_cnt_reg is the index of the beat handshaking now; index arlen must be last.
        if (r_hs) begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
          if (bus.m_rlast_i) begin
            if (beat_cnt_reg != len_reg) proto_err_next = 1'b1;
            last_grant_next = owner_reg;
            state_next      = RD_ARB_IDLE;
          end else if (beat_cnt_reg == len_reg) begin
            proto_err_next = 1'b1;
          end
        end
      end
`ifdef HAWK_RD_ARB_TIMEOUT_EN
      RD_ARB_ABORT: begin
        if (|(bus.req_rready_i & owner_onehot)) begin
          last_grant_next = owner_reg;
          state_next      = RD_ARB_IDLE;
        end
      end
`endif
      default: state_next = RD_ARB_IDLE;
    endcase
`ifdef HAWK_RD_ARB_TIMEOUT_EN
    to_cnt_next = to_cnt_reg;
    to_err_next = to_err_reg;
    if (state_reg == RD_ARB_IDLE) begin
      to_cnt_next = '0;
    end else if (state_reg == RD_ARB_ADDR || state_reg == RD_ARB_DATA) begin
      // A cycle that makes progress never times out.
      if (r_hs) begin
        to_cnt_next = '0;
      end else if (state_next == state_reg && to_cnt_reg >= TW'(TIMEOUT_CYC - 1)) begin
        to_err_next = 1'b1;
        state_next  = RD_ARB_ABORT;
      end else begin
        to_cnt_next = to_cnt_reg + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg      <= RD_ARB_IDLE;
      owner_reg      <= '0;
      last_grant_reg <= OW'(NUM_REQ - 1);
      addr_reg       <= '0;
      len_reg        <= '0;
      beat_cnt_reg   <= '0;
      proto_err_reg  <= 1'b0;
`ifdef HAWK_RD_ARB_TIMEOUT_EN
      to_cnt_reg     <= '0;
      to_err_reg     <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      addr_reg       <= addr_next;
      len_reg        <= len_next;
      beat_cnt_reg   <= beat_cnt_next;
      proto_err_reg  <= proto_err_next;
`ifdef HAWK_RD_ARB_TIMEOUT_EN
      to_cnt_reg     <= to_cnt_next;
      to_err_reg     <= to_err_next;
`endif
    end
  end

  assign busy_o      = (state_reg != RD_ARB_IDLE);
  assign owner_o     = owner_reg;
  assign proto_err_o = proto_err_reg;
`ifdef HAWK_RD_ARB_TIMEOUT_EN
  assign timeout_err_o = to_err_reg;
`else
  // Watchdog compiled out; the parameter stays referenced so every build elaborates it.
  assign timeout_err_o = (TIMEOUT_CYC == 0) ? 1'b0 : 1'b0;
`endif
endmodule

// File: tb/tb_hawk_rd_arbiter.sv
// Self-checking bench for hawk_rd_arbiter: transaction-level model plus directed tests.
// The watchdog test runs only when HAWK_RD_ARB_TIMEOUT_EN is defined.
module tb_hawk_rd_arbiter;
  import hacd_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TO_CYC  = 16;
  localparam int OW      = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  hawk_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic          busy_o;
  logic [OW-1:0] owner_o;
  logic          proto_err_o;
  logic          timeout_err_o;

  hawk_rd_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .bus           (bus.slave),
    .busy_o        (busy_o),
    .owner_o       (owner_o),
    .proto_err_o   (proto_err_o),
    .timeout_err_o (timeout_err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 address offered, 2 data, 3 synthetic abort beat
  int          md_phase, md_owner, md_last, md_beats, md_tcnt;
  logic [31:0] md_addr;
  int          md_len;
  logic        md_proto, md_terr;
  int          md_win;

  function automatic int rr_winner(input logic [NUM_REQ-1:0] req, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (req[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  always_comb md_win = rr_winner(bus.req_arvalid_i, md_last);

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      md_phase <= 0; md_owner <= 0; md_last <= NUM_REQ - 1; md_beats <= 0;
      md_addr <= '0; md_len <= 0; md_proto <= 1'b0; md_tcnt <= 0; md_terr <= 1'b0;
    end else begin
      case (md_phase)
        0: begin
          if (bus.m_rvalid_i) md_proto <= 1'b1;
          if (md_win >= 0) begin
            md_owner <= md_win;
            md_addr  <= bus.req_addr_i[md_win*ADDR_W +: ADDR_W];
            md_len   <= int'(bus.req_arlen_i[md_win*8 +: 8]);
            md_phase <= 1;
          end
          md_tcnt <= 0;
        end
        1: begin
          if (bus.m_rvalid_i) md_proto <= 1'b1;
          if (bus.m_arready_i) begin md_phase <= 2; md_beats <= 0; end
        end
        2: begin
          if (bus.m_rvalid_i && bus.req_rready_i[md_owner]) begin
            md_beats <= md_beats + 1;
            if (bus.m_rlast_i) begin
              if (md_beats + 1 != md_len + 1) md_proto <= 1'b1;
              md_phase <= 0;
              md_last  <= md_owner;
            end else if (md_beats + 1 == md_len + 1) begin
              md_proto <= 1'b1;
            end
          end
        end
        3: begin
          if (bus.req_rready_i[md_owner]) begin md_phase <= 0; md_last <= md_owner; end
        end
        default: md_phase <= 0;
      endcase
`ifdef HAWK_RD_ARB_TIMEOUT_EN
      if (md_phase == 1 || md_phase == 2) begin
        if (md_phase == 2 && bus.m_rvalid_i && bus.req_rready_i[md_owner]) md_tcnt <= 0;
        else if (!(md_phase == 1 && bus.m_arready_i) && md_tcnt + 1 >= TO_CYC) begin
          md_phase <= 3; md_terr <= 1'b1;
        end else md_tcnt <= md_tcnt + 1;
      end
`endif
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    logic [NUM_REQ-1:0] oh;
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      oh = '0;
      oh[md_owner] = 1'b1;
      chk("busy", busy_o, md_phase != 0);
      chk("owner", owner_o, md_owner);
      chk("m_arvalid", bus.m_arvalid_o, md_phase == 1);
      if (md_phase == 1) begin
        chk("m_addr", bus.m_addr_o, md_addr);
        chk("m_arlen", bus.m_arlen_o, md_len);
      end
      chk("req_arready", bus.req_arready_o, (md_phase == 1 && bus.m_arready_i) ? oh : '0);
      chk("m_rready", bus.m_rready_o, (md_phase == 2) ? bus.req_rready_i[md_owner] : 1'b0);
      chk("req_rvalid", bus.req_rvalid_o,
          ((md_phase == 2 && bus.m_rvalid_i) || md_phase == 3) ? oh : '0);
      chk("r_rdata", bus.r_rdata_o, (md_phase == 2) ? bus.m_rdata_i : '0);
      chk("r_rresp", bus.r_rresp_o,
          (md_phase == 2) ? bus.m_rresp_i : (md_phase == 3) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
      chk("r_rlast", bus.r_rlast_o, (md_phase == 2) ? bus.m_rlast_i : (md_phase == 3));
      chk("proto_err", proto_err_o, md_proto);
      chk("timeout_err", timeout_err_o, md_terr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_arvalid_i = '0; bus.req_addr_i = '0; bus.req_arlen_i = '0; bus.req_rready_i = '0;
    bus.m_arready_i = 1'b0; bus.m_rvalid_i = 1'b0; bus.m_rlast_i = 1'b0;
    bus.m_rdata_i = '0; bus.m_rresp_i = 2'b00;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic [7:0] len);
    bus.req_arvalid_i[i]           = 1'b1;
    bus.req_addr_i[i*ADDR_W +: 32] = addr;
    bus.req_arlen_i[i*8 +: 8]      = len;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int order [5];
    int delivered;
    clear_inputs();

    // Test 1: single request from requester 2
    do_reset();
    @(negedge clk_i);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_owner", owner_o, 2'd0);
    chk("rst_arvalid", bus.m_arvalid_o, 1'b0);
    chk("rst_proto", proto_err_o, 1'b0);
    step();
    set_req(2, 32'h1000, 8'd0);
    step();
    bus.m_arready_i = 1'b1;
    @(negedge clk_i);
    chk("t1_arvalid_n1", bus.m_arvalid_o, 1'b1);
    chk("t1_addr", bus.m_addr_o, 32'h1000);
    chk("t1_arready", bus.req_arready_o, 4'b0100);
    step();
    bus.req_arvalid_i = '0; bus.m_arready_i = 1'b0;
    bus.m_rvalid_i = 1'b1; bus.m_rlast_i = 1'b1; bus.m_rdata_i = 32'hCAFE0001;
    bus.req_rready_i = 4'b0100;
    @(negedge clk_i);
    chk("t1_rvalid", bus.req_rvalid_o, 4'b0100);
    chk("t1_rdata", bus.r_rdata_o, 32'hCAFE0001);
    step();
    bus.m_rvalid_i = 1'b0; bus.m_rlast_i = 1'b0;
    @(negedge clk_i);
    chk("t1_busy_fall", busy_o, 1'b0);

    // Test 2: fairness with all four requesters active
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h100 * (i + 1), 8'd0);
    bus.req_rready_i = 4'hF;
    for (int g = 0; g < 5; g++) begin
      step();
      bus.m_arready_i = 1'b1;
      @(negedge clk_i);
      order[g] = int'(owner_o);
      step();
      bus.m_arready_i = 1'b0; bus.m_rvalid_i = 1'b1; bus.m_rlast_i = 1'b1;
      bus.m_rdata_i = 32'hF000 + 32'(g);
      step();
      bus.m_rvalid_i = 1'b0; bus.m_rlast_i = 1'b0;
    end
    chk("t2_order0", order[0], 0);
    chk("t2_order1", order[1], 1);
    chk("t2_order2", order[2], 2);
    chk("t2_order3", order[3], 3);
    chk("t2_order4", order[4], 0);

    // Test 3: arlen=3 with owner toggling rready
    do_reset();
    set_req(1, 32'h2000, 8'd3);
    step();
    bus.m_arready_i = 1'b1;
    step();
    bus.m_arready_i = 1'b0; bus.req_arvalid_i = '0;
    delivered = 0;
    for (int c = 0; c < 30 && delivered < 4; c++) begin
      bus.m_rvalid_i = 1'b1;
      bus.m_rdata_i  = 32'hB000 + 32'(delivered);
      bus.m_rlast_i  = (delivered == 3);
      bus.req_rready_i[1] = (c % 2 == 0);
      @(negedge clk_i);
      if (bus.req_rvalid_o[1] && bus.req_rready_i[1]) begin
        chk("t3_beat_data", bus.r_rdata_o, 32'hB000 + 32'(delivered));
        delivered++;
      end
      step();
    end
    bus.m_rvalid_i = 1'b0; bus.m_rlast_i = 1'b0; bus.req_rready_i = '0;
    chk("t3_beats", delivered, 4);
    @(negedge clk_i);
    chk("t3_proto", proto_err_o, 1'b0);
    chk("t3_idle", busy_o, 1'b0);

    // Test 4a: early rlast on beat 2 of an arlen=3 burst
    do_reset();
    set_req(0, 32'h3000, 8'd3);
    step();
    bus.m_arready_i = 1'b1;
    step();
    bus.m_arready_i = 1'b0; bus.req_arvalid_i = '0;
    bus.req_rready_i = 4'b0001; bus.m_rvalid_i = 1'b1; bus.m_rlast_i = 1'b0;
    step();
    bus.m_rlast_i = 1'b1;
    step();
    bus.m_rvalid_i = 1'b0; bus.m_rlast_i = 1'b0;
    @(negedge clk_i);
    chk("t4_early_last_proto", proto_err_o, 1'b1);
    chk("t4_early_last_idle", busy_o, 1'b0);

    // Test 4b: stray R beat while idle
    do_reset();
    bus.m_rvalid_i = 1'b1; bus.m_rdata_i = 32'hDEAD; bus.req_rready_i = 4'hF;
    @(negedge clk_i);
    chk("t4_stray_pre", proto_err_o, 1'b0);
    chk("t4_stray_fwd", bus.req_rvalid_o, 4'b0000);
    chk("t4_stray_data", bus.r_rdata_o, 32'h0);
    step();
    bus.m_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("t4_stray_proto", proto_err_o, 1'b1);

    // Test 5: reset during beat 1 of 4, then a normal request
    do_reset();
    set_req(3, 32'h4000, 8'd3);
    step();
    bus.m_arready_i = 1'b1;
    step();
    bus.m_arready_i = 1'b0; bus.req_arvalid_i = '0;
    bus.req_rready_i = 4'b1000; bus.m_rvalid_i = 1'b1;
    step();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("t5_beat1_fwd", bus.req_rvalid_o, 4'b1000);
    step();
    @(negedge clk_i);
    chk("t5_rst_busy", busy_o, 1'b0);
    chk("t5_rst_rready", bus.m_rready_o, 1'b0);
    chk("t5_rst_rvalid", bus.req_rvalid_o, 4'b0000);
    chk("t5_rst_owner", owner_o, 2'd0);
    step();
    clear_inputs();
    rst_ni = 1'b1;
    set_req(2, 32'h5000, 8'd0);
    step();
    bus.m_arready_i = 1'b1;
    @(negedge clk_i);
    chk("t5_new_owner", owner_o, 2'd2);
    chk("t5_new_addr", bus.m_addr_o, 32'h5000);
    step();
    bus.m_arready_i = 1'b0; bus.req_arvalid_i = '0;
    bus.m_rvalid_i = 1'b1; bus.m_rlast_i = 1'b1; bus.req_rready_i = 4'b0100;
    step();
    bus.m_rvalid_i = 1'b0; bus.m_rlast_i = 1'b0;
    @(negedge clk_i);
    chk("t5_new_done", busy_o, 1'b0);
    chk("t5_new_proto", proto_err_o, 1'b0);

`ifdef HAWK_RD_ARB_TIMEOUT_EN
    // Test 6: slave never answers
    begin
      int waited;
      do_reset();
      set_req(0, 32'h6000, 8'd0);
      step();
      bus.m_arready_i = 1'b1;
      step();
      bus.m_arready_i = 1'b0; bus.req_arvalid_i = '0;
      waited = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk_i);
        if (timeout_err_o) break;
        step();
        waited++;
      end
      chk("t6_cycles", waited + 1, 16);
      chk("t6_to_flag", timeout_err_o, 1'b1);
      chk("t6_abort_rvalid", bus.req_rvalid_o, 4'b0001);
      chk("t6_abort_rlast", bus.r_rlast_o, 1'b1);
      chk("t6_abort_rresp", bus.r_rresp_o, 2'b10);
      chk("t6_abort_rdata", bus.r_rdata_o, 32'h0);
      step();
      bus.req_rready_i = 4'b0001;
      step();
      bus.req_rready_i = '0;
      @(negedge clk_i);
      chk("t6_idle", busy_o, 1'b0);
      chk("t6_sticky", timeout_err_o, 1'b1);
    end
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
